// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response handshakes between a command source and the ALU sequencer.
interface alu_cmd_sequencer_if #(parameter int WIDTH = 16);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_func;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_carry;
  logic [3:0]         rsp_func;
  logic               rsp_error;
  modport master (
    output cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_error
  );
  modport slave (
    input  cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_func, rsp_error
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to alu_top, waits for the selected unit flag (with watchdog)
// and returns the formatted result over a valid/ready response handshake.
module alu_cmd_sequencer #(
  parameter int WIDTH     = 16,
  parameter int TIMEOUT   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_func,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  input  logic                 carry_out,
  input  logic [2*WIDTH-1:0]   arith_out,
  input  logic [WIDTH-1:0]     logic_out,
  input  logic [WIDTH:0]       shift_out,
  input  logic [2:0]           cmp_out,
  output logic [CNT_WIDTH-1:0] op_count
);
  localparam int WD_W = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]           alu_func_q, alu_func_d, rsp_func_q, rsp_func_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_error_q, rsp_error_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 sel_flag;
  logic [2*WIDTH-1:0]   result;
  // Unit select follows the registered opcode, so flags from other units never match.
  always_comb begin
    sel_flag = alu_func_q[3] ? (alu_func_q[2] ? shift_flag : cmp_flag)
                             : (alu_func_q[2] ? logic_flag : arith_flag);
    result   = alu_func_q[3] ? (alu_func_q[2] ? (2*WIDTH)'(shift_out) : (2*WIDTH)'(cmp_out))
                             : (alu_func_q[2] ? (2*WIDTH)'(logic_out) : arith_out);
  end
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    rsp_func_d  = rsp_func_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_error_d = rsp_error_q;
    op_count_d  = op_count_q;
    wd_d        = wd_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = !(bus.cmd_valid && cmd_ready_q);
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_a_d    = bus.cmd_a;
          alu_b_d    = bus.cmd_b;
          alu_func_d = bus.cmd_func;
          rsp_func_d = bus.cmd_func;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_flag || wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = !sel_flag;
          rsp_data_d  = sel_flag ? result : '0;
          rsp_carry_d = sel_flag && alu_func_q[3:2] == 2'b00 && carry_out;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_func_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_error_q <= 1'b0;
      op_count_q  <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      rsp_func_q  <= rsp_func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_error_q <= rsp_error_d;
      op_count_q  <= op_count_d;
      wd_q        <= wd_d;
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_func  = rsp_func_q;
  assign bus.rsp_error = rsp_error_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_func      = alu_func_q;
  assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer driving a behavioural alu_top model.
module tb_alu_cmd_sequencer;
  localparam int W  = 16;
  localparam int TO = 8;
  typedef struct packed {logic [31:0] d; logic c; logic [3:0] f; logic e;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0] alu_func;
  logic arith_flag, logic_flag, cmp_flag, shift_flag, carry_out;
  logic [2*W-1:0] arith_out;
  logic [W-1:0] logic_out;
  logic [W:0] shift_out;
  logic [2:0] cmp_out;
  logic [1:0] op_count;
  logic [1:0] exp_cnt = 2'd0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int since = 100;
  int fdel = 1;
  bit flag_en = 1'b1;
  bit stray = 1'b0;
  rsp_t sb[$];
  alu_cmd_sequencer_if #(.WIDTH(W)) bus();
  alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .carry_out(carry_out), .arith_out(arith_out), .logic_out(logic_out),
    .shift_out(shift_out), .cmp_out(cmp_out), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Model ALU: flag of the selected unit rises fdel cycles after the accept edge.
  always @(posedge clk or negedge rst)
    if (!rst) since <= 100;
    else if (bus.cmd_valid && bus.cmd_ready) since <= 0;
    else if (since < 100) since <= since + 1;
  logic fl;
  logic [16:0] s17, d17;
  always_comb begin
    fl         = flag_en && since == fdel;
    arith_flag = (fl && alu_func[3:2] == 2'd0) || (stray && since == 1);
    logic_flag = fl && alu_func[3:2] == 2'd1;
    cmp_flag   = fl && alu_func[3:2] == 2'd2;
    shift_flag = fl && alu_func[3:2] == 2'd3;
    s17        = {1'b0, alu_a} + {1'b0, alu_b};
    d17        = {1'b0, alu_a} - {1'b0, alu_b};
    carry_out  = alu_func[1:0] == 2'd0 ? s17[16] : alu_func[1:0] == 2'd1 ? d17[16] : 1'b0;
    arith_out  = alu_func[1:0] == 2'd0 ? {{16{alu_a[15]}}, alu_a} + {{16{alu_b[15]}}, alu_b} :
                 alu_func[1:0] == 2'd1 ? {{16{alu_a[15]}}, alu_a} - {{16{alu_b[15]}}, alu_b} :
                 alu_func[1:0] == 2'd2 ? {{16{alu_a[15]}}, alu_a} * {{16{alu_b[15]}}, alu_b} : 32'd0;
    logic_out  = alu_func[1:0] == 2'd0 ? alu_a & alu_b : alu_func[1:0] == 2'd1 ? alu_a | alu_b :
                 alu_func[1:0] == 2'd2 ? alu_a ^ alu_b : ~alu_a;
    shift_out  = alu_func[0] ? {1'b0, alu_a >> alu_b[3:0]} : {1'b0, alu_a} << alu_b[3:0];
    cmp_out    = {$signed(alu_a) > $signed(alu_b), alu_a == alu_b, $signed(alu_a) < $signed(alu_b)};
  end
  function automatic rsp_t obs();
    return {bus.rsp_data, bus.rsp_carry, bus.rsp_func, bus.rsp_error};
  endfunction
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, output int acc, output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready) begin
        @(negedge clk);
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    int acc;
    bit ok;
    flag_en = 1'b0;
    send(4'h0, 16'd5, 16'd3, acc, ok);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cmd_ready, alu_a, alu_b, alu_func, bus.rsp_valid, bus.rsp_data, bus.rsp_carry,
         bus.rsp_func, bus.rsp_error, op_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got a=%h func=%h ready=%b valid=%b want all zero", alu_a, alu_func, bus.cmd_ready, bus.rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    n_cmp++;
    if (op_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", op_count); end
    flag_en = 1'b1;
  endtask
  task automatic test_add();
    int acc;
    bit ok;
    rsp_t e;
    bus.rsp_ready = 1'b1;
    sb.push_back(rsp_t'{32'd8, 1'b0, 4'h0, 1'b0});
    send(4'h0, 16'd5, 16'd3, acc, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL add_accept: got %b want 1", ok); end
    wait_rsp(ok);
    n_cmp++;
    if (cyc - acc !== 2 || ok !== 1'b1) begin n_bad++; $display("FAIL add_latency: got %0d want 2", cyc - acc); end
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL add_rsp: got %h want %h", obs(), e); end
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if (op_count !== exp_cnt || bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_handoff: got cnt=%0d valid=%b want cnt=%0d valid=0", op_count, bus.rsp_valid, exp_cnt);
    end
  endtask
  task automatic test_backpressure();
    int acc;
    bit ok;
    bit bad;
    rsp_t e, first;
    bus.rsp_ready = 1'b0;
    sb.push_back(rsp_t'{32'hFFFF_FFF5, 1'b0, 4'h1, 1'b0});
    send(4'h1, 16'hFFFC, 16'd7, acc, ok);
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || ok !== 1'b1) begin n_bad++; $display("FAIL sub_rsp: got %h want %h", obs(), e); end
    first = obs();
    bad = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = 4'h5;
    repeat (10) begin
      @(negedge clk);
      if (obs() !== first || bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || alu_func !== 4'h1) bad = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin n_bad++; $display("FAIL hold_stable: got rsp=%h ready=%b func=%h want rsp=%h ready=0 func=1", obs(), bus.cmd_ready, alu_func, first); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if (op_count !== exp_cnt || bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL sub_handoff: got cnt=%0d valid=%b want cnt=%0d valid=0", op_count, bus.rsp_valid, exp_cnt);
    end
  endtask
  task automatic test_cmp_stray();
    int acc;
    bit ok;
    rsp_t e;
    fdel  = 3;
    stray = 1'b1;
    sb.push_back(rsp_t'{32'h2, 1'b0, 4'h8, 1'b0});
    send(4'h8, 16'd9, 16'd9, acc, ok);
    wait_rsp(ok);
    n_cmp++;
    if (cyc - acc !== 4 || ok !== 1'b1) begin n_bad++; $display("FAIL cmp_latency: got %0d want 4", cyc - acc); end
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL cmp_rsp: got %h want %h", obs(), e); end
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if (op_count !== exp_cnt) begin n_bad++; $display("FAIL cmp_count: got %0d want %0d", op_count, exp_cnt); end
    fdel  = 1;
    stray = 1'b0;
  endtask
  task automatic test_timeout();
    int acc;
    bit ok;
    rsp_t e;
    flag_en = 1'b0;
    sb.push_back(rsp_t'{32'd0, 1'b0, 4'hC, 1'b1});
    send(4'hC, 16'h0003, 16'd2, acc, ok);
    wait_rsp(ok);
    n_cmp++;
    if (cyc - acc !== TO + 1 || ok !== 1'b1) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", cyc - acc, TO + 1); end
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL timeout_rsp: got %h want %h", obs(), e); end
    @(negedge clk);
    exp_cnt++;
    n_cmp++;
    if (op_count !== exp_cnt) begin n_bad++; $display("FAIL timeout_count: got %0d want %0d", op_count, exp_cnt); end
    flag_en = 1'b1;
  endtask
  task automatic test_back_to_back();
    logic [3:0]  f[4] = '{4'h0, 4'h6, 4'hC, 4'h2};
    logic [15:0] a[4] = '{16'hFFFF, 16'h00F0, 16'h8001, 16'hFFFE};
    logic [15:0] b[4] = '{16'h0001, 16'h0FF0, 16'h0001, 16'h0003};
    bus.rsp_ready = 1'b1;
    sb.push_back(rsp_t'{32'h0000_0000, 1'b1, 4'h0, 1'b0});
    sb.push_back(rsp_t'{32'h0000_0F00, 1'b0, 4'h6, 1'b0});
    sb.push_back(rsp_t'{32'h0001_0002, 1'b0, 4'hC, 1'b0});
    sb.push_back(rsp_t'{32'hFFFF_FFFA, 1'b0, 4'h2, 1'b0});
    fork
      begin
        int prev;
        int acc;
        prev = -100;
        for (int i = 0; i < 4; i++) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_func  = f[i];
          bus.cmd_a     = a[i];
          bus.cmd_b     = b[i];
          for (int k = 0; k < 40 && !bus.cmd_ready; k++) @(negedge clk);
          n_cmp++;
          if (bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept%0d: got ready=%b want 1", i, bus.cmd_ready);
            break;
          end
          @(negedge clk);
          acc = cyc;
          if (i > 0) begin
            n_cmp++;
            if (acc - prev < 4) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want >=4", i, acc - prev); end
          end
          prev = acc;
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        bit ok;
        rsp_t e;
        for (int i = 0; i < 4; i++) begin
          wait_rsp(ok);
          e = sb.pop_front();
          n_cmp++;
          if (ok !== 1'b1 || obs() !== e) begin n_bad++; $display("FAIL b2b_rsp%0d: got %h want %h", i, obs(), e); end
          @(negedge clk);
          exp_cnt++;
          n_cmp++;
          if (op_count !== exp_cnt) begin n_bad++; $display("FAIL b2b_count%0d: got %0d want %0d", i, op_count, exp_cnt); end
        end
      end
    join
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_func  = 4'h0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_backpressure();
    test_cmp_stray();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
